// File: rtl/uart_cmd_responder_if.sv
// Signal bundle between the host-link UART responder and its surroundings:
// the serial pins plus the command/response handshake with the command processor.
interface uart_cmd_responder_if;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        tx_busy;
    logic        resp_sent;
    logic        frame_err;

    // Host side / command processor side: drives RX and the request inputs
    modport master (
        output RX, clr_cmd_rdy, resp, send_resp,
        input  TX, cmd, cmd_rdy, tx_busy, resp_sent, frame_err
    );

    // Responder side
    modport slave (
        input  RX, clr_cmd_rdy, resp, send_resp,
        output TX, cmd, cmd_rdy, tx_busy, resp_sent, frame_err
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Robot-side end of the host command link.
// RX: 8N1 deserialiser feeding a two-byte assembler (high byte first) that
// presents a 16-bit command with a sticky ready flag.
// TX: 8N1 serialiser for single-byte responses, full duplex with RX.
module uart_cmd_responder #(
    parameter int BAUD_DIV     = 5208,
    parameter int BYTE_TIMEOUT = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    uart_cmd_responder_if.slave bus
);

    localparam int BAUD_W = $clog2(BAUD_DIV + 1);
    localparam int TO_W   = $clog2(BYTE_TIMEOUT + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BYTE_TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {WAIT_HI, WAIT_LO}                     asm_state_t;
    typedef enum logic       {TX_IDLE, TX_SHIFT}                    tx_state_t;

    // ------------------------------------------------------------------
    // RX synchroniser and start-edge detect
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;
    logic start_edge;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign start_edge = rx_prev_q & ~rx_sync_q;

    // ------------------------------------------------------------------
    // RX bit engine
    // ------------------------------------------------------------------
    rx_state_t         rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]        rx_bit_q,   rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              byte_valid;
    logic              byte_err;

    // RX engine state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state: half-bit start check, then mid-bit samples, LSB first.
    // byte_valid/byte_err strobe in the cycle the stop bit is sampled; the
    // assembled byte is already complete in rx_shift_q at that point.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (start_edge) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // A start bit that is high again at mid-bit was a glitch
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + BAUD_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + BAUD_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        byte_err = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + BAUD_ONE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte-pair assembler
    // ------------------------------------------------------------------
    asm_state_t      asm_state_q, asm_state_d;
    logic [7:0]      hi_byte_q,   hi_byte_d;
    logic [TO_W-1:0] to_cnt_q,    to_cnt_d;
    logic [15:0]     cmd_q,       cmd_d;
    logic            cmd_rdy_q,   cmd_rdy_d;
    logic            frame_err_q, frame_err_d;
    logic            pair_done;

    // Assembler state register
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_state_q <= WAIT_HI;
            hi_byte_q   <= '0;
            to_cnt_q    <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            asm_state_q <= asm_state_d;
            hi_byte_q   <= hi_byte_d;
            to_cnt_q    <= to_cnt_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Assembler next state: pairs bytes, drops a stale high byte on timeout or
    // framing error. The inter-byte timer only runs while the receiver is idle,
    // so a start edge on the low byte freezes it.
    always_comb begin
        asm_state_d = asm_state_q;
        hi_byte_d   = hi_byte_q;
        to_cnt_d    = to_cnt_q;
        cmd_d       = cmd_q;
        pair_done   = 1'b0;
        frame_err_d = byte_err;
        case (asm_state_q)
            WAIT_HI: begin
                if (byte_valid) begin
                    hi_byte_d   = rx_shift_q;
                    to_cnt_d    = '0;
                    asm_state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (byte_valid) begin
                    cmd_d       = {hi_byte_q, rx_shift_q};
                    pair_done   = 1'b1;
                    asm_state_d = WAIT_HI;
                end else if (byte_err) begin
                    asm_state_d = WAIT_HI;
                end else if (rx_state_q == RX_IDLE && !start_edge) begin
                    if (to_cnt_q == TO_LAST) begin
                        asm_state_d = WAIT_HI;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_ONE;
                    end
                end
            end
            default: begin
                asm_state_d = WAIT_HI;
            end
        endcase
        // Completion takes priority over a simultaneous clear
        if (pair_done) begin
            cmd_rdy_d = 1'b1;
        end else if (bus.clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end else begin
            cmd_rdy_d = cmd_rdy_q;
        end
    end

    // ------------------------------------------------------------------
    // TX serialiser
    // ------------------------------------------------------------------
    tx_state_t         tx_state_q,  tx_state_d;
    logic [BAUD_W-1:0] tx_cnt_q,    tx_cnt_d;
    logic [3:0]        tx_bit_q,    tx_bit_d;
    logic [8:0]        tx_shift_q,  tx_shift_d;
    logic              tx_q,        tx_d;
    logic              resp_sent_q, resp_sent_d;

    // TX state register; the line idles high and returns high on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '1;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // TX next state: tx_q carries the bit currently on the line; tx_shift_q
    // holds the remaining data bits with the stop bit on top. Bit index 0 is
    // the start bit, 9 the stop bit.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_d        = tx_q;
        resp_sent_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (bus.send_resp) begin
                    tx_shift_d = {1'b1, bus.resp};
                    tx_d       = 1'b0;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_d        = 1'b1;
                        resp_sent_d = 1'b1;
                        tx_state_d  = TX_IDLE;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[8:1]};
                        tx_bit_d   = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + BAUD_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    assign bus.TX        = tx_q;
    assign bus.tx_busy   = (tx_state_q == TX_SHIFT);
    assign bus.resp_sent = resp_sent_q;
    assign bus.cmd       = cmd_q;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder with a short baud divisor.
// RX bytes are driven by a bit-level BFM; expected commands go into a
// scoreboard queue and are popped when cmd_rdy rises.
module tb_uart_cmd_responder;

    localparam int BAUD_DIV     = 16;
    localparam int BYTE_TIMEOUT = 400;

    logic clk;
    logic rst;

    uart_cmd_responder_if bus_if ();

    uart_cmd_responder #(
        .BAUD_DIV     (BAUD_DIV),
        .BYTE_TIMEOUT (BYTE_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int rise_cyc = 0;
    int rise_cnt = 0;
    int ferr_cnt = 0;
    int rs_cnt = 0;
    bit rdy_prev = 1'b0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int          gap;
        logic        push;
        logic [15:0] exp_cmd;
        int          exp_ferr;
    } rx_vec_t;

    rx_vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // Monitor: counts pulses and pops the scoreboard on each cmd_rdy rise
    initial forever begin
        @(negedge clk);
        if (bus_if.frame_err === 1'b1) ferr_cnt++;
        if (bus_if.resp_sent === 1'b1) rs_cnt++;
        if (bus_if.cmd_rdy === 1'b1 && !rdy_prev) begin
            rise_cyc = cyc;
            rise_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: actual=%0h required=none", bus_if.cmd);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("sb_cmd", {16'h0, bus_if.cmd}, {16'h0, e});
            end
        end
        rdy_prev = (bus_if.cmd_rdy === 1'b1);
    end

    // Serial RX driver: start, 8 data LSB first, stop, then idle gap
    task automatic rx_byte(input logic [7:0] d, input logic stop, input int gap);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        @(posedge clk);
        #1;
        last_fall = cyc;
        for (int i = 0; i < 10; i++) begin
            bus_if.RX = frame[i];
            repeat (BAUD_DIV) @(posedge clk);
            #1;
        end
        bus_if.RX = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic clr_pulse();
        @(posedge clk);
        #1;
        bus_if.clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus_if.clr_cmd_rdy = 1'b0;
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Sends one response and checks every bit mid-cell, plus end timing.
    // With inject set, a second request arrives mid-frame and must be ignored.
    task automatic tx_frame(input logic [7:0] r, input bit inject);
        logic [9:0] frame;
        int t0;
        int n;
        bit busy_seen;
        frame = {1'b1, r, 1'b0};
        @(posedge clk);
        #1;
        bus_if.resp = r;
        bus_if.send_resp = 1'b1;
        @(posedge clk);
        #1;
        bus_if.send_resp = 1'b0;
        t0 = cyc;
        check("tx_start_low", {31'h0, bus_if.TX}, 32'h0);
        check("tx_busy_set", {31'h0, bus_if.tx_busy}, 32'h1);
        for (int k = 0; k < 10; k++) begin
            repeat (BAUD_DIV / 2) @(posedge clk);
            #1;
            check($sformatf("tx_bit%0d", k), {31'h0, bus_if.TX}, {31'h0, frame[k]});
            if (inject && k == 3) begin
                bus_if.resp = ~r;
                bus_if.send_resp = 1'b1;
                @(posedge clk);
                #1;
                bus_if.send_resp = 1'b0;
                repeat (BAUD_DIV / 2 - 1) @(posedge clk);
                #1;
            end else begin
                repeat (BAUD_DIV / 2) @(posedge clk);
                #1;
            end
        end
        n = 0;
        while (bus_if.resp_sent !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("resp_sent_delay", cyc - t0, 32'd160);
        check("tx_busy_clear", {31'h0, bus_if.tx_busy}, 32'h0);
        busy_seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus_if.tx_busy !== 1'b0 || bus_if.TX !== 1'b1) busy_seen = 1'b1;
        end
        check("tx_no_requeue", {31'h0, busy_seen}, 32'h0);
    endtask

    initial begin
        int fb;
        int rb;
        bit seen;

        // Byte-level stimulus table: data, stop bit, idle gap, expected cmd
        vecs[0] = '{8'h5A, 1'b1, 401, 1'b0, 16'h0000, 0}; // hi byte then timeout
        vecs[1] = '{8'h12, 1'b1, 20,  1'b0, 16'h0000, 0};
        vecs[2] = '{8'h34, 1'b1, 20,  1'b1, 16'h1234, 0};
        vecs[3] = '{8'h77, 1'b0, 20,  1'b0, 16'h0000, 1}; // bad stop bit
        vecs[4] = '{8'hAB, 1'b1, 20,  1'b0, 16'h0000, 0};
        vecs[5] = '{8'hCD, 1'b1, 20,  1'b1, 16'hABCD, 0};
        vecs[6] = '{8'h00, 1'b1, 300, 1'b0, 16'h0000, 0}; // long gap under timeout
        vecs[7] = '{8'hFF, 1'b1, 20,  1'b1, 16'h00FF, 0};
        vecs[8] = '{8'hFF, 1'b1, 20,  1'b0, 16'h0000, 0};
        vecs[9] = '{8'h00, 1'b1, 20,  1'b1, 16'hFF00, 0};

        rst = 1'b1;
        bus_if.RX = 1'b1;
        bus_if.clr_cmd_rdy = 1'b0;
        bus_if.resp = 8'h00;
        bus_if.send_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_TX", {31'h0, bus_if.TX}, 32'h1);
        check("rst_cmd", {16'h0, bus_if.cmd}, 32'h0);
        check("rst_cmd_rdy", {31'h0, bus_if.cmd_rdy}, 32'h0);
        check("rst_tx_busy", {31'h0, bus_if.tx_busy}, 32'h0);
        check("rst_resp_sent", {31'h0, bus_if.resp_sent}, 32'h0);
        check("rst_frame_err", {31'h0, bus_if.frame_err}, 32'h0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Command 0x2900, ready latency and sticky ready
        rb = rise_cnt;
        exp_q.push_back(16'h2900);
        rx_byte(8'h29, 1'b1, 10);
        rx_byte(8'h00, 1'b1, 30);
        #1;
        check("t1_rise_count", rise_cnt - rb, 32'd1);
        check("t1_rdy_latency_ok",
              {31'h0, (rise_cyc - last_fall >= 153) && (rise_cyc - last_fall <= 157)}, 32'h1);
        check("t1_cmd", {16'h0, bus_if.cmd}, 32'h2900);
        check("t1_rdy_held", {31'h0, bus_if.cmd_rdy}, 32'h1);
        clr_pulse();
        check("t1_rdy_cleared", {31'h0, bus_if.cmd_rdy}, 32'h0);

        // Response 0xA5 with an ignored mid-frame request
        tx_frame(8'hA5, 1'b1);

        // Table-driven RX sequences
        foreach (vecs[i]) begin
            fb = ferr_cnt;
            if (vecs[i].push) exp_q.push_back(vecs[i].exp_cmd);
            rx_byte(vecs[i].data, vecs[i].stop, vecs[i].gap);
            #1;
            check($sformatf("vec%0d_ferr", i), ferr_cnt - fb, vecs[i].exp_ferr);
            check($sformatf("vec%0d_rdy", i), {31'h0, bus_if.cmd_rdy}, {31'h0, vecs[i].push});
            if (vecs[i].push) begin
                check($sformatf("vec%0d_cmd", i), {16'h0, bus_if.cmd}, {16'h0, vecs[i].exp_cmd});
                clr_pulse();
                check($sformatf("vec%0d_clr", i), {31'h0, bus_if.cmd_rdy}, 32'h0);
            end
        end

        // Full duplex: 0x4321 received while 0x5A transmits; clear held across completion
        rb = rise_cnt;
        exp_q.push_back(16'h4321);
        seen = 1'b0;
        fork
            begin
                rx_byte(8'h43, 1'b1, 5);
                fork
                    rx_byte(8'h21, 1'b1, 10);
                    begin
                        repeat (146) @(posedge clk);
                        #1;
                        bus_if.clr_cmd_rdy = 1'b1;
                        repeat (20) begin
                            @(posedge clk);
                            #1;
                            if (bus_if.cmd_rdy === 1'b1) seen = 1'b1;
                        end
                        bus_if.clr_cmd_rdy = 1'b0;
                    end
                join
            end
            tx_frame(8'h5A, 1'b0);
        join
        check("t6_set_wins", {31'h0, seen}, 32'h1);
        check("t6_rise_count", rise_cnt - rb, 32'd1);
        check("t6_cmd", {16'h0, bus_if.cmd}, 32'h4321);

        // Reset during TX data bit 3
        @(posedge clk);
        #1;
        bus_if.resp = 8'hA5;
        bus_if.send_resp = 1'b1;
        @(posedge clk);
        #1;
        bus_if.send_resp = 1'b0;
        repeat (69) @(posedge clk);
        #1;
        check("t5_bit3_low", {31'h0, bus_if.TX}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_TX", {31'h0, bus_if.TX}, 32'h1);
        check("t5_rst_busy", {31'h0, bus_if.tx_busy}, 32'h0);
        rst = 1'b0;
        fb = rs_cnt;
        repeat (200) @(posedge clk);
        #1;
        check("t5_no_resp_sent", rs_cnt - fb, 32'd0);

        // Reset between the two bytes of 0x1111
        rb = rise_cnt;
        rx_byte(8'h11, 1'b1, 10);
        rst_pulse();
        rx_byte(8'h11, 1'b1, 20);
        #1;
        check("t5_no_cmd_rdy", {31'h0, bus_if.cmd_rdy}, 32'h0);
        check("t5_no_rise", rise_cnt - rb, 32'd0);
        check("t5_cmd_cleared", {16'h0, bus_if.cmd}, 32'h0);
        rst_pulse();
        repeat (10) @(posedge clk);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
